// File: rtl/addsub_seq.sv
// Multi-word add/subtract sequencer: runs one 16-bit add/sub slice per cycle,
// least-significant word first, chaining the carry to form a WORDS*16-bit result.

module addsub_slice16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_inv,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_c15,
    output logic        o_cout
);
    logic [16:0] w_c;
    logic [15:0] w_b;

    assign w_b    = i_b ^ {16{i_inv}};
    assign w_c[0] = i_cin;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign o_sum[i]   = i_a[i] ^ w_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & w_b[i]) | (w_c[i] & (i_a[i] ^ w_b[i]));
    end

    // Carry into the sign bit is exported so the caller can form signed overflow.
    assign o_c15  = w_c[15];
    assign o_cout = w_c[16];
endmodule

module addsub_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [16*WORDS-1:0]   op_a,
    input  logic [16*WORDS-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic [16*WORDS-1:0]   result,
    output logic                  carry,
    output logic                  overflow
);
    localparam int unsigned W  = 16 * WORDS;
    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_mode;
    logic          r_cin;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_result;
    logic          r_carry;
    logic          r_ovf;

    logic          w_accept;
    logic          w_run;
    logic          w_last;
    logic [31:0]   w_base;
    logic [15:0]   w_a_word;
    logic [15:0]   w_b_word;
    logic [15:0]   w_sum;
    logic          w_c15;
    logic          w_cout;
    logic [W-1:0]  w_merged;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_k == K_LAST) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Requests are only honoured from IDLE or DONE; RUN ignores start entirely.
    assign w_accept = start && (r_state != S_RUN);
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_k == K_LAST);

    assign w_base   = 32'(r_k) * 32'd16;
    assign w_a_word = r_a[w_base +: 16];
    assign w_b_word = r_b[w_base +: 16];

    addsub_slice16 u_slice (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_inv  (r_mode),
        .i_cin  (r_cin),
        .o_sum  (w_sum),
        .o_c15  (w_c15),
        .o_cout (w_cout)
    );

    // Accumulator with the current word replaced, so the final cycle can load
    // the complete result in the same edge that writes the last word.
    always_comb begin
        w_merged = r_acc;
        w_merged[w_base +: 16] = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_cin    <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a    <= op_a;
            r_b    <= op_b;
            r_mode <= mode;
            r_cin  <= mode;
            r_k    <= '0;
        end else if (w_run) begin
            r_acc <= w_merged;
            r_cin <= w_cout;
            if (w_last) begin
                r_k      <= '0;
                r_result <= w_merged;
                r_carry  <= w_cout;
                r_ovf    <= w_c15 ^ w_cout;
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq at WORDS=4 and WORDS=1 against an arithmetic reference model.

module tb_addsub_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s4_start, s4_mode, s4_busy, s4_done, s4_carry, s4_ovf;
    logic [63:0] s4_a, s4_b, s4_result;
    logic        s1_start, s1_mode, s1_busy, s1_done, s1_carry, s1_ovf;
    logic [15:0] s1_a, s1_b, s1_result;

    int n_checks = 0;
    int n_errors = 0;

    addsub_seq #(.WORDS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .mode(s4_mode),
        .op_a(s4_a), .op_b(s4_b), .busy(s4_busy), .done(s4_done),
        .result(s4_result), .carry(s4_carry), .overflow(s4_ovf)
    );

    addsub_seq #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .mode(s1_mode),
        .op_a(s1_a), .op_b(s1_b), .busy(s1_busy), .done(s1_done),
        .result(s1_result), .carry(s1_carry), .overflow(s1_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Signed overflow = true signed result does not fit; carry = unsigned carry / no-borrow.
    function automatic void model64(input logic [63:0] a, input logic [63:0] b, input logic m,
                                    output logic [63:0] r, output logic c, output logic v);
        logic signed [65:0] sa, sb, s;
        logic [64:0] u;
        sa = $signed({{2{a[63]}}, a});
        sb = $signed({{2{b[63]}}, b});
        s  = m ? (sa - sb) : (sa + sb);
        u  = {1'b0, a} + {1'b0, b};
        r  = s[63:0];
        c  = m ? (a >= b) : u[64];
        v  = (s > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -66'sh0_8000_0000_0000_0000);
    endfunction

    function automatic void model16(input logic [15:0] a, input logic [15:0] b, input logic m,
                                    output logic [15:0] r, output logic c, output logic v);
        int sa, sb, s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        s  = m ? (sa - sb) : (sa + sb);
        r  = m ? (a - b) : (a + b);
        c  = m ? (a >= b) : ((32'(a) + 32'(b)) > 32'hFFFF);
        v  = (s > 32767) || (s < -32768);
    endfunction

    task automatic wait_done4(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!s4_done && cnt < 20);
    endtask

    task automatic check4(input string tag, input logic [63:0] a, input logic [63:0] b, input logic m);
        logic [63:0] er;
        logic ec, ev;
        model64(a, b, m, er, ec, ev);
        chk({tag, "_done"}, 64'(s4_done), 64'd1);
        chk({tag, "_busy_in_done"}, 64'(s4_busy), 64'd0);
        chk({tag, "_result"}, s4_result, er);
        chk({tag, "_carry"}, 64'(s4_carry), 64'(ec));
        chk({tag, "_ovf"}, 64'(s4_ovf), 64'(ev));
    endtask

    task automatic run4(input string tag, input logic [63:0] a, input logic [63:0] b, input logic m);
        int cnt;
        @(negedge clk);
        s4_start = 1'b1; s4_a = a; s4_b = b; s4_mode = m;
        @(posedge clk); #1;
        chk({tag, "_busy"}, 64'(s4_busy), 64'd1);
        @(negedge clk);
        s4_start = 1'b0; s4_a = {$urandom, $urandom}; s4_b = {$urandom, $urandom}; s4_mode = 1'($urandom);
        // the negedge above precedes E1, so counting starts with E1
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!s4_done && cnt < 20);
        chk({tag, "_latency"}, 64'(cnt), 64'd4);
        check4(tag, a, b, m);
    endtask

    task automatic run1(input string tag, input logic [15:0] a, input logic [15:0] b, input logic m);
        logic [15:0] er;
        logic ec, ev;
        int cnt;
        model16(a, b, m, er, ec, ev);
        @(negedge clk);
        s1_start = 1'b1; s1_a = a; s1_b = b; s1_mode = m;
        @(posedge clk); #1;
        chk({tag, "_busy"}, 64'(s1_busy), 64'd1);
        s1_start = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!s1_done && cnt < 10);
        chk({tag, "_latency"}, 64'(cnt), 64'd1);
        chk({tag, "_busy_in_done"}, 64'(s1_busy), 64'd0);
        chk({tag, "_result"}, 64'(s1_result), 64'(er));
        chk({tag, "_carry"}, 64'(s1_carry), 64'(ec));
        chk({tag, "_ovf"}, 64'(s1_ovf), 64'(ev));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] er, ra, rb, ha, hb;
        logic ec, ev, rm, saw_done;
        int cnt;

        rst_n = 1'b0;
        s4_start = 1'b0; s4_mode = 1'b0; s4_a = '0; s4_b = '0;
        s1_start = 1'b0; s1_mode = 1'b0; s1_a = '0; s1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(s4_busy), 64'd0);
        chk("rst_done", 64'(s4_done), 64'd0);
        chk("rst_result", s4_result, 64'd0);
        chk("rst_carry", 64'(s4_carry), 64'd0);
        chk("rst_ovf", 64'(s4_ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run4("add_chain", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        run4("sub_neg", 64'h0, 64'h1, 1'b1);
        run4("sub_zero", 64'h5, 64'h5, 1'b1);
        run4("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        run4("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1);

        // start pulsed during RUN must not disturb the operation in flight
        ha = 64'h1234_5678_9ABC_DEF0; hb = 64'h0FED_CBA9_8765_4321;
        @(negedge clk);
        s4_start = 1'b1; s4_a = ha; s4_b = hb; s4_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s4_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s4_start = 1'b1; s4_a = 64'hFFFF_0000_FFFF_0000; s4_b = 64'h1111_1111_1111_1111; s4_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s4_start = 1'b0;
        wait_done4(cnt);
        chk("ign_latency", 64'(cnt), 64'd2);
        check4("ign", ha, hb, 1'b0);
        @(posedge clk); #1;
        chk("ign_no_rerun_busy", 64'(s4_busy), 64'd0);
        chk("ign_no_rerun_done", 64'(s4_done), 64'd0);

        // back-to-back: start held through DONE launches the next operation
        ha = 64'hAAAA_5555_AAAA_5555; hb = 64'h5555_AAAA_5555_AAAB;
        ra = 64'h0000_0001_0000_0000; rb = 64'h0000_0000_0000_0001;
        @(negedge clk);
        s4_start = 1'b1; s4_a = ha; s4_b = hb; s4_mode = 1'b0;
        @(posedge clk); #1;
        wait_done4(cnt);
        chk("b2b_first_latency", 64'(cnt), 64'd4);
        check4("b2b_first", ha, hb, 1'b0);
        s4_a = ra; s4_b = rb; s4_mode = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        chk("b2b_second_busy", 64'(s4_busy), 64'd1);
        model64(ha, hb, 1'b0, er, ec, ev);
        chk("b2b_hold_during_run", s4_result, er);
        wait_done4(cnt);
        chk("b2b_done_spacing", 64'(cnt + 1), 64'd5);
        check4("b2b_second", ra, rb, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        model64(ra, rb, 1'b1, er, ec, ev);
        chk("hold_idle_result", s4_result, er);

        // asynchronous reset while k==2 aborts the operation
        @(negedge clk);
        s4_start = 1'b1; s4_a = 64'h0123_4567_89AB_CDEF; s4_b = 64'h1; s4_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s4_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(s4_busy), 64'd0);
        chk("mid_rst_done", 64'(s4_done), 64'd0);
        chk("mid_rst_result", s4_result, 64'd0);
        chk("mid_rst_carry", 64'(s4_carry), 64'd0);
        chk("mid_rst_ovf", 64'(s4_ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (s4_done) saw_done = 1'b1;
        end
        chk("mid_rst_no_done", 64'(saw_done), 64'd0);
        run4("post_rst_add", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rm = 1'($urandom);
            if (i % 6 == 0) rb = ra;
            run4($sformatf("rnd4_%0d", i), ra, rb, rm);
        end

        run1("w1_add", 16'hFFFF, 16'h0001, 1'b0);
        run1("w1_sub_ovf", 16'h8000, 16'h0001, 1'b1);
        for (int i = 0; i < 16; i++) begin
            run1($sformatf("rnd1_%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
